// File: rtl/sound_pkg.sv
// Shared types and constant note ROMs for the stacker-game sound sequencer.
package sound_pkg;

    localparam int MAX_NOTES = 4;
    localparam int ROM_HP_W  = 16;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_PLACE = 2'd1,
        EV_MISS  = 2'd2,
        EV_WIN   = 2'd3
    } event_t;

    typedef struct packed {
        logic [ROM_HP_W-1:0] half_period;
        logic [7:0]          dur;
    } note_t;

    typedef note_t [MAX_NOTES-1:0] seq_t;

    function automatic note_t mk_note(input logic [ROM_HP_W-1:0] hp, input logic [7:0] dur);
        note_t n;
        n.half_period = hp;
        n.dur         = dur;
        return n;
    endfunction

    localparam note_t NOTE_END = '0;

    // Entry 0 sits in the least significant slot; dur == 0 ends the sequence.
    localparam seq_t PLACE_ROM = {NOTE_END, NOTE_END, NOTE_END, mk_note(16'd10, 8'd3)};
    localparam seq_t MISS_ROM  = {NOTE_END, mk_note(16'd30, 8'd2), mk_note(16'd0, 8'd1),
                                  mk_note(16'd20, 8'd2)};
    localparam seq_t WIN_ROM   = {NOTE_END, mk_note(16'd4, 8'd4), mk_note(16'd6, 8'd2),
                                  mk_note(16'd8, 8'd2)};

    function automatic note_t rom_note(input event_t ev, input logic [1:0] idx);
        case (ev)
            EV_PLACE: return PLACE_ROM[idx];
            EV_MISS:  return MISS_ROM[idx];
            EV_WIN:   return WIN_ROM[idx];
            default:  return NOTE_END;
        endcase
    endfunction

    function automatic logic [7:0] rom_dur(input event_t ev, input logic [1:0] idx);
        note_t n;
        n = rom_note(ev, idx);
        return n.dur;
    endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave tone generator: toggles speaker every half_period enabled cycles.
module tone_gen #(
    parameter int HP_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [HP_W-1:0] half_period,
    input  logic            load,
    input  logic            enable,
    output logic            speaker
);

    logic [HP_W-1:0] cnt;

    // A zero half period is a rest, so it behaves like a continuous load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            speaker <= 1'b0;
        end else if (load || (half_period == '0)) begin
            cnt     <= '0;
            speaker <= 1'b0;
        end else if (enable) begin
            if (cnt == half_period - 1'b1) begin
                cnt     <= '0;
                speaker <= ~speaker;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Priority-arbitrated event sound sequencer; SOUND_PREEMPT_EN lets a higher
// priority pending event abort the current sequence at the next tick wrap.
//
//  state    | meaning
//  ST_IDLE  | silent, waiting for a pending event
//  ST_PLAY  | current note sounding, tick/duration counters running
//  ST_NEXT  | one-cycle step to next note, next event, or idle
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int HP_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_place,
    input  logic       req_miss,
    input  logic       req_win,
    output logic [2:0] ack,
    output logic       busy,
    output logic [1:0] cur_event,
    output logic       speaker
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_NEXT} state_t;

    state_t          state, state_next;
    event_t          ev, ev_next, grant_ev;
    logic [1:0]      idx, idx_next;
    logic [TW-1:0]   tick, tick_next;
    logic [7:0]      dcnt, dcnt_next;
    logic [2:0]      pending, grant_oh, grant_clr, ack_next;
    logic            tone_load, tick_wrap, dur_done, play_exit, seq_end;
    note_t           cur_note;

    assign cur_note  = rom_note(ev, idx);
    assign tick_wrap = (tick == TICK_LAST);
    assign dur_done  = (dcnt == cur_note.dur - 8'd1);

    always_comb begin
        grant_ev = EV_NONE;
        grant_oh = 3'b000;
        if (pending[2]) begin
            grant_ev = EV_WIN;
            grant_oh = 3'b100;
        end else if (pending[1]) begin
            grant_ev = EV_MISS;
            grant_oh = 3'b010;
        end else if (pending[0]) begin
            grant_ev = EV_PLACE;
            grant_oh = 3'b001;
        end
    end

`ifdef SOUND_PREEMPT_EN
    logic abort, higher_pending;

    always_comb begin
        case (ev)
            EV_NONE:  higher_pending = |pending;
            EV_PLACE: higher_pending = |pending[2:1];
            EV_MISS:  higher_pending = pending[2];
            default:  higher_pending = 1'b0;
        endcase
    end

    // Remembers that the sequence was cut short so the coming NEXT ends it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            abort <= 1'b0;
        else if (state == ST_PLAY && tick_wrap)
            abort <= higher_pending;
    end

    assign play_exit = dur_done || higher_pending;
    assign seq_end   = (idx == 2'd3) || (rom_dur(ev, idx + 2'd1) == 8'd0) || abort;
`else
    assign play_exit = dur_done;
    assign seq_end   = (idx == 2'd3) || (rom_dur(ev, idx + 2'd1) == 8'd0);
`endif

    always_comb begin
        state_next = state;
        ev_next    = ev;
        idx_next   = idx;
        tick_next  = tick;
        dcnt_next  = dcnt;
        ack_next   = 3'b000;
        grant_clr  = 3'b000;
        tone_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                tone_load = 1'b1;
                ev_next   = EV_NONE;
                if (pending != 3'b000) begin
                    state_next = ST_PLAY;
                    ev_next    = grant_ev;
                    idx_next   = 2'd0;
                    tick_next  = '0;
                    dcnt_next  = 8'd0;
                    ack_next   = grant_oh;
                    grant_clr  = grant_oh;
                end
            end
            ST_PLAY: begin
                if (tick_wrap) begin
                    tick_next = '0;
                    dcnt_next = dcnt + 8'd1;
                    if (play_exit)
                        state_next = ST_NEXT;
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            ST_NEXT: begin
                idx_next  = idx + 2'd1;
                tick_next = '0;
                dcnt_next = 8'd0;
                tone_load = 1'b1;
                if (!seq_end) begin
                    state_next = ST_PLAY;
                end else if (pending != 3'b000) begin
                    state_next = ST_PLAY;
                    ev_next    = grant_ev;
                    idx_next   = 2'd0;
                    ack_next   = grant_oh;
                    grant_clr  = grant_oh;
                end else begin
                    state_next = ST_IDLE;
                    ev_next    = EV_NONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ev      <= EV_NONE;
            idx     <= 2'd0;
            tick    <= '0;
            dcnt    <= 8'd0;
            ack     <= 3'b000;
            pending <= 3'b000;
        end else begin
            state   <= state_next;
            ev      <= ev_next;
            idx     <= idx_next;
            tick    <= tick_next;
            dcnt    <= dcnt_next;
            ack     <= ack_next;
            // A request arriving on the grant edge re-arms the bit for a replay.
            pending <= (pending & ~grant_clr) | {req_win, req_miss, req_place};
        end
    end

    assign busy      = (state != ST_IDLE);
    assign cur_event = ev;

    tone_gen #(.HP_W(HP_W)) u_tone (
        .clock       (clock),
        .reset       (reset),
        .half_period (HP_W'(cur_note.half_period)),
        .load        (tone_load),
        .enable      (state == ST_PLAY),
        .speaker     (speaker)
    );

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Event-driven sound controller for the stacker game. It accepts one-cycle event requests from game logic (block placed, block missed/game over, tower won), arbitrates them by fixed priority, and plays each event's short note sequence from a constant ROM. It drives a square-wave tone generator whose output goes straight to the board speaker pin. It replaces free-running-counter beeps with sequenced, bounded-length cues.

## Interface
- `TICK_DIV`, default 1_000_000: clocks per duration tick (10 ms at 100 MHz); minimum 2.
- `HP_W`, default 16: width of a note half-period count.
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_place`  in  1: one-cycle pulse, block placed.
- `req_miss`  in  1: one-cycle pulse, block missed / game over.
- `req_win`  in  1: one-cycle pulse, tower complete.
- `ack`  out  3: one-hot grant pulse {win, miss, place}, high for exactly one cycle when a sequence starts.
- `busy`  out  1: high while a sequence is playing.
- `cur_event`  out  2: 0 = none, 1 = place, 2 = miss, 3 = win.
- `speaker`  out  1: square-wave audio output.

## Operation
- Each `req_*` high on a clock edge sets the matching `pending` bit. A repeat request while the bit is already set is merged.
- Priority: win > miss > place.
- ROM entry is {half_period[HP_W-1:0], dur[7:0]}, with up to 4 entries per event. `dur == 0` or index 3 completed terminates the sequence. `half_period == 0` is a rest: speaker held 0.
- ROM contents:
  - place: {10,3}
  - miss: {20,2}, {0,1}, {30,2}
  - win: {8,2}, {6,2}, {4,4}
- FSM states:
  - IDLE: if any pending bit is set, select the highest-priority event, clear its pending bit, pulse `ack`, set note index 0, go to PLAY.
  - PLAY: tick counter counts 0..TICK_DIV-1. Each wrap increments the duration count. When the duration count reaches `dur`, go to NEXT.
  - NEXT (1 cycle): increment the index. If the sequence has ended, go to IDLE (or directly to PLAY of the next pending event, with `ack`). Otherwise go to PLAY with the tick and duration counters cleared.
- Tone generator: a half-period counter counts to `half_period-1`, then toggles `speaker`. The counter and `speaker` clear to 0 on note load, in IDLE, and on rests.
- A request for the event currently playing is latched as pending and replays after the current sequence ends.
- Simultaneous requests: all bits latch. They are served in priority order, back to back.
- Reset mid-sequence: immediate return to IDLE; all pending bits cleared; speaker 0.

## Timing
- Reset values: `ack = 0`, `busy = 0`, `cur_event = 0`, `speaker = 0`, pending = 0, state = IDLE.
- Request sampled at edge N, with the FSM idle:
  - pending set after edge N;
  - `ack`, `busy`, `cur_event` valid after edge N+1;
  - first speaker toggle `half_period` cycles later.
- Each note occupies exactly `dur*TICK_DIV` PLAY cycles plus 1 NEXT cycle.
- `busy` drops one cycle after the final NEXT, unless another event is pending. In that case `busy` stays high and the next `ack` pulses in that same cycle.
- `speaker` is registered. There is no combinational path from `req_*` to any output.

## Configuration
- `SOUND_PREEMPT_EN` defined:
  - A pending event of strictly higher priority than `cur_event` aborts the current sequence at the next tick wrap.
  - It goes through NEXT and starts the new event; the aborted event is dropped, not re-queued.
- Not defined: sequences always run to completion and preemption logic is absent.

## Structure
- Package `sound_pkg`:
  - event enum (NONE/PLACE/MISS/WIN);
  - note struct typedef;
  - the three note ROM constants;
  - `MAX_NOTES = 4`.
- Sub-module `tone_gen`: half-period counter plus toggle flop, with inputs `half_period` and `load`/`enable`. Everything else lives in `sound_sequencer`.

## Test plan
- Run with `TICK_DIV = 100`.
- Reset asserted mid-win sequence: next cycle `speaker = 0`, `busy = 0`, `cur_event = 0`. A `req_miss` queued before the reset is not played.
- Single `req_place`: `ack = 3'b001` two edges later. `speaker` toggles every 10 cycles for 300 cycles (15 periods), then `busy` falls.
- `req_miss`: 200 cycles of period 40, then 100 cycles of `speaker = 0` (plus 1 NEXT cycle), then 200 cycles of period 60.
- `req_place` and `req_win` in the same cycle: win plays first (`ack = 3'b100`). Place follows with no idle gap (`ack = 3'b001`, `busy` continuously high).
- Three `req_place` pulses during a place sequence: exactly one replay follows.
- With `SOUND_PREEMPT_EN`, `req_win` 50 cycles into place: the switch occurs at cycle 100 (tick wrap), `cur_event = 3`, and place is not resumed. Without the macro, place completes all 300 cycles first.
